// File: rtl/divi.sv
// Sequential signed divider: result = trunc((register*8)/immediate), immediate in Q2.3.
// Restoring division on magnitudes, one quotient bit per cycle, saturated to 8-bit signed.
module divi (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic signed [7:0] register,
  input  logic signed [4:0] immediate,
  output logic              busy,
  output logic              done,
  output logic signed [7:0] result,
  output logic              div_zero,
  output logic              overflow
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  count_reg;
  logic [10:0] quo_reg;
  logic [4:0]  rem_reg;
  logic [4:0]  dvs_reg;
  logic        neg_reg;

  logic        accept;
  logic        imm_zero;
  logic [10:0] dvd;
  logic [10:0] dvd_mag;
  logic [4:0]  dvs_mag;
  logic [5:0]  shifted;
  logic        ge;
  logic [4:0]  diff;
  logic [4:0]  rem_next;
  logic [10:0] quo_next;
  logic [7:0]  sat_result;
  logic        sat_ovf;

  assign accept   = start && (state_reg != CALC);
  assign imm_zero = (immediate == 5'sd0);

  // register sign-extended to 11 bits then shifted left 3 is just register with 3 zero LSBs
  assign dvd     = {register, 3'b000};
  assign dvd_mag = register[7] ? (11'd0 - dvd) : dvd;
  assign dvs_mag = immediate[4] ? (5'd0 - $unsigned(immediate)) : $unsigned(immediate);

  // One restoring step: the remainder is always below the divisor (<= 16), so 5 bits suffice
  assign shifted  = {rem_reg, quo_reg[10]};
  assign ge       = (shifted >= {1'b0, dvs_reg});
  assign diff     = shifted[4:0] - dvs_reg;
  assign rem_next = ge ? diff : shifted[4:0];
  assign quo_next = {quo_reg[9:0], ge};

  always_comb begin
    sat_result = 8'h00;
    sat_ovf    = 1'b0;
    if (neg_reg) begin
      if (quo_next > 11'd128) begin
        sat_result = 8'h80;
        sat_ovf    = 1'b1;
      end else begin
        sat_result = 8'd0 - quo_next[7:0];
      end
    end else begin
      if (quo_next > 11'd127) begin
        sat_result = 8'h7F;
        sat_ovf    = 1'b1;
      end else begin
        sat_result = quo_next[7:0];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = imm_zero ? DONE : CALC;
      CALC: if (count_reg == 4'd10) state_next = DONE;
      DONE: begin
        if (accept) state_next = imm_zero ? DONE : CALC;
        else        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= 4'd0;
      quo_reg   <= 11'd0;
      rem_reg   <= 5'd0;
      dvs_reg   <= 5'd0;
      neg_reg   <= 1'b0;
      result    <= 8'h00;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
    end else if (accept) begin
      if (imm_zero) begin
        result   <= register[7] ? 8'h80 : 8'h7F;
        div_zero <= 1'b1;
        overflow <= 1'b0;
      end else begin
        quo_reg   <= dvd_mag;
        rem_reg   <= 5'd0;
        dvs_reg   <= dvs_mag;
        neg_reg   <= register[7] ^ immediate[4];
        count_reg <= 4'd0;
      end
    end else if (state_reg == CALC) begin
      quo_reg   <= quo_next;
      rem_reg   <= rem_next;
      count_reg <= count_reg + 4'd1;
      if (count_reg == 4'd10) begin
        result   <= sat_result;
        overflow <= sat_ovf;
        div_zero <= 1'b0;
      end
    end
  end

  assign busy = (state_reg == CALC);
  assign done = (state_reg == DONE);

endmodule

// File: tb/tb_divi.sv
// Directed bench for divi: fixed vectors with hand-computed quotients, timing,
// divide-by-zero, start-while-busy, and reset abort.
module tb_divi;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic signed [7:0] register = 8'sd0;
  logic signed [4:0] immediate = 5'sd0;
  logic              busy, done, div_zero, overflow;
  logic signed [7:0] result;

  int n_cmp = 0;
  int n_bad = 0;

  divi dut (
    .clk(clk), .reset(reset), .start(start), .register(register),
    .immediate(immediate), .busy(busy), .done(done), .result(result),
    .div_zero(div_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Issues one start, scrambles the operands right after the accept edge,
  // and reports cycles until done (0 = done right at the accept edge).
  task automatic run_op(input logic [7:0] r, input logic [4:0] i,
                        output int lat, output int busy_cycles);
    @(negedge clk);
    register = r; immediate = i; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; register = 8'h5A; immediate = 5'b01011;
    lat = 0; busy_cycles = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cycles++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, div_zero, overflow, result} !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b dz=%b ovf=%b res=%h, want all 0",
               busy, done, div_zero, overflow, result);
    end
    reset = 1'b0;
  endtask

  task automatic test_vectors();
    logic [7:0]  vr [7]  = '{8'd6, 8'd7, 8'h80, 8'hC0, 8'd8, 8'hF9, 8'd0};
    logic [4:0]  vi [7]  = '{5'b00110, 5'b11101, 5'b00100, 5'b00100, 5'b01100, 5'b11000, 5'b00101};
    logic [7:0]  vq [7]  = '{8'h08, 8'hEE, 8'h80, 8'h80, 8'h05, 8'h07, 8'h00};
    logic        vo [7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    int lat, bc;
    for (int k = 0; k < 7; k++) begin
      run_op(vr[k], vi[k], lat, bc);
      n_cmp++;
      if (result !== vq[k] || overflow !== vo[k] || div_zero !== 1'b0) begin
        n_bad++;
        $display("FAIL vec%0d_value: got res=%h ovf=%b dz=%b, want res=%h ovf=%b dz=0",
                 k, result, overflow, div_zero, vq[k], vo[k]);
      end
      n_cmp++;
      if (lat !== 11 || bc !== 11) begin
        n_bad++;
        $display("FAIL vec%0d_timing: got latency=%0d busy_cycles=%0d, want 11/11", k, lat, bc);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0 || result !== vq[k]) begin
        n_bad++;
        $display("FAIL vec%0d_after: got done=%b busy=%b res=%h, want 0/0/%h",
                 k, done, busy, result, vq[k]);
      end
    end
  endtask

  task automatic test_div_zero();
    int lat, bc;
    run_op(8'd5, 5'b00000, lat, bc);
    n_cmp++;
    if (lat !== 0 || bc !== 0 || result !== 8'h7F || div_zero !== 1'b1 || overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL dz_pos: got lat=%0d busy_cycles=%0d res=%h dz=%b ovf=%b, want 0/0/7f/1/0",
               lat, bc, result, div_zero, overflow);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || div_zero !== 1'b1) begin
      n_bad++;
      $display("FAIL dz_pulse: got done=%b busy=%b dz=%b, want 0/0/1", done, busy, div_zero);
    end
    run_op(8'hFF, 5'b00000, lat, bc);
    n_cmp++;
    if (lat !== 0 || result !== 8'h80 || div_zero !== 1'b1 || overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL dz_neg: got lat=%0d res=%h dz=%b ovf=%b, want 0/80/1/0",
               lat, result, div_zero, overflow);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int k, m;
    @(negedge clk);
    register = 8'd6; immediate = 5'b00110; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    register = 8'd7; immediate = 5'b11101; start = 1'b1;   // sampled at N+4
    @(posedge clk); #1;
    start = 1'b0;
    k = 4;
    while (!done && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    n_cmp++;
    if (k !== 11 || result !== 8'h08) begin
      n_bad++;
      $display("FAIL busy_ignore: got done_at=%0d res=%h, want 11/08", k, result);
    end
    register = 8'hC0; immediate = 5'b00100; start = 1'b1;  // start in the DONE cycle
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0 || result !== 8'h08) begin
      n_bad++;
      $display("FAIL done_accept: got busy=%b done=%b res=%h, want 1/0/08", busy, done, result);
    end
    m = 0;
    while (!done && m < 40) begin
      @(posedge clk); #1;
      m++;
    end
    n_cmp++;
    if (m !== 11 || result !== 8'h80 || overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL done_accept_result: got lat=%0d res=%h ovf=%b, want 11/80/0", m, result, overflow);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    int lat, bc, pulses;
    @(negedge clk);
    register = 8'd7; immediate = 5'b11101; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;                                          // sampled at N+5
    @(posedge clk); #1;
    reset = 1'b0;
    n_cmp++;
    if ({busy, done, div_zero, overflow, result} !== 12'h000) begin
      n_bad++;
      $display("FAIL abort_outputs: got busy=%b done=%b dz=%b ovf=%b res=%h, want all 0",
               busy, done, div_zero, overflow, result);
    end
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_bad++;
      $display("FAIL abort_no_done: got %0d active cycles, want 0", pulses);
    end
    run_op(8'd8, 5'b01100, lat, bc);
    n_cmp++;
    if (lat !== 11 || result !== 8'h05 || overflow !== 1'b0 || div_zero !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset_op: got lat=%0d res=%h ovf=%b dz=%b, want 11/05/0/0",
               lat, result, overflow, div_zero);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_div_zero();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
